// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Imported by the register file top and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;
  localparam int MAX_WR    = 4;

  // Returns {valid, port}; the highest-index asserted hit wins.
  function automatic logic [2:0] win_port(input logic [MAX_WR-1:0] hits);
    logic [2:0] w_win;
    w_win = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hits[p]) w_win = {1'b1, 2'(p)};
    end
    return w_win;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard: reserve sets a bit, a write clears it,
// and a reserve in the same cycle as a write to the same register wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NWR   = 1,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_clr = '0;
    for (int n = 0; n < NREGS; n++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(n))) w_clr[n] = 1'b1;
      end
    end
  end

  always_comb begin
    w_busy_nxt = r_busy;
    for (int n = 0; n < NREGS; n++) begin
      if (n == ZERO_REG) begin
        w_busy_nxt[n] = 1'b0;
      end else if (rsv_en && (rsv_addr == AW'(n))) begin
        w_busy_nxt[n] = 1'b1;
      end else if (w_clr[n]) begin
        w_busy_nxt[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with hardwired-zero x0, optional
// write-to-read bypass and a pending-write scoreboard for RAW detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busy_vec;

  // Ports are applied in ascending order so the highest-index write lands last.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NREGS; n++) r_regs[n] <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] != AW'(ZERO_REG))) begin
          r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (w_busy_vec)
  );

  assign busy_vec = w_busy_vec;

  // Reads are zero-latency; outputs are forced to zero while reset is held
  // so a bypassed write cannot leak through during reset.
  always_comb begin
    logic [AW-1:0]     w_addr;
    logic [MAX_WR-1:0] w_hits;
    logic [2:0]        w_win;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      w_addr = rd_addr[i*AW +: AW];
      w_hits = '0;
      for (int p = 0; p < NWR; p++) begin
        w_hits[p] = wr_en[p] && (wr_addr[p*AW +: AW] == w_addr);
      end
      w_win = win_port(w_hits);
      rd_data[i*XLEN +: XLEN] = r_regs[w_addr];
      rd_busy[i]              = w_busy_vec[w_addr];
      if ((BYPASS != 0) && w_win[2]) begin
        rd_data[i*XLEN +: XLEN] = wr_data[int'(w_win[1:0])*XLEN +: XLEN];
        rd_busy[i]              = 1'b0;
      end
      if ((w_addr == AW'(ZERO_REG)) || !reset_n) begin
        rd_data[i*XLEN +: XLEN] = '0;
        rd_busy[i]              = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on / bypass off, two write ports)
// checked every cycle against an array model plus hand-computed directed values.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [31:0] busy_a, busy_b;

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_on  = 1'b0;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_a (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_a),
    .rd_busy  (rd_busy_a),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_b (
    .clock    (clock),
    .reset_n  (reset_n),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data_b),
    .rd_busy  (rd_busy_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_b)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [31:0] m_busy_nxt;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < 32; n++) m_regs[n] = 32'h0;
      m_busy = 32'h0;
    end else begin
      m_busy_nxt = m_busy;
      for (int n = 1; n < 32; n++) begin
        for (int p = 0; p < 2; p++) begin
          if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == n) m_busy_nxt[n] = 1'b0;
        end
        if (rsv_en && int'(rsv_addr) == n) m_busy_nxt[n] = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p*5 +: 5] != 5'd0) m_regs[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
      end
      m_busy = m_busy_nxt;
    end
  end

  function automatic void exp_read(input int a, input bit byp,
                                   output logic [31:0] d, output logic b);
    d = m_regs[a];
    b = m_busy[a];
    if (byp) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && int'(wr_addr[p*5 +: 5]) == a) begin
          d = wr_data[p*32 +: 32];
          b = 1'b0;
        end
      end
    end
    if (a == 0 || !reset_n) begin
      d = 32'h0;
      b = 1'b0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  logic [31:0] c_d;
  logic        c_b;

  always @(negedge clock) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        exp_read(int'(rd_addr[i*5 +: 5]), 1'b1, c_d, c_b);
        check("cmp_a_data", rd_data_a[i*32 +: 32], c_d);
        check("cmp_a_busy", 32'(rd_busy_a[i]), 32'(c_b));
        exp_read(int'(rd_addr[i*5 +: 5]), 1'b0, c_d, c_b);
        check("cmp_b_data", rd_data_b[i*32 +: 32], c_d);
        check("cmp_b_busy", 32'(rd_busy_b[i]), 32'(c_b));
      end
      check("cmp_a_busy_vec", busy_a, m_busy);
      check("cmp_b_busy_vec", busy_b, m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  task automatic drive_wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]            = 1'b1;
    wr_addr[p*5 +: 5]   = 5'(a);
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic check_both(input string name, input logic [31:0] exp_a, input logic [31:0] exp_b);
    check({name, "_a0"}, rd_data_a[31:0],  exp_a);
    check({name, "_a1"}, rd_data_a[63:32], exp_a);
    check({name, "_b0"}, rd_data_b[31:0],  exp_b);
    check({name, "_b1"}, rd_data_b[63:32], exp_b);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset_n  = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    tick();
    cmp_on = 1'b1;

    // reset held: even a bypassable write must read as zero
    drive_wr(0, 6, 32'hCAFEF00D);
    rd(6, 6);
    #1 check_both("rst_held_bypass", 32'h0, 32'h0);
    check("rst_held_busy_a", 32'(rd_busy_a), 32'h0);
    tick();
    idle();
    tick();
    reset_n = 1'b1;
    tick();

    // test 1: every address reads zero after reset
    for (int a = 0; a < 32; a++) begin
      rd(a, 31 - a);
      #1 check_both("rst_sweep", 32'h0, 32'h0);
    end
    check("rst_busy_a", busy_a, 32'h0);
    check("rst_busy_b", busy_b, 32'h0);
    tick();

    drive_wr(0, 5, 32'hDEADBEEF);
    rd(5, 5);
    #1 check_both("x5_wr_cycle", 32'hDEADBEEF, 32'h0);
    tick();
    idle();
    #1 check_both("x5_after", 32'hDEADBEEF, 32'hDEADBEEF);
    reset_n = 1'b0;
    #1 check_both("x5_async_rst", 32'h0, 32'h0);
    reset_n = 1'b1;
    tick();
    #1 check_both("x5_post_rst", 32'h0, 32'h0);

    // test 2: x0 ignores writes and reservations
    drive_wr(0, 0, 32'hFFFFFFFF);
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    rd(0, 0);
    #1 check_both("x0_wr_cycle", 32'h0, 32'h0);
    tick();
    idle();
    #1 check_both("x0_after", 32'h0, 32'h0);
    check("x0_busy_a", 32'(busy_a[0]), 32'h0);
    check("x0_busy_b", 32'(busy_b[0]), 32'h0);
    tick();

    // test 3: bypass vs stored read
    drive_wr(0, 7, 32'h12345678);
    rd(7, 7);
    #1 check_both("x7_wr_cycle", 32'h12345678, 32'h0);
    check("x7_rd_busy_a", 32'(rd_busy_a), 32'h0);
    tick();
    idle();
    #1 check_both("x7_after", 32'h12345678, 32'h12345678);
    tick();

    // test 4: two ports to one register, highest index wins
    drive_wr(0, 9, 32'h11);
    drive_wr(1, 9, 32'h22);
    rd(9, 9);
    #1 check_both("x9_wr_cycle", 32'h22, 32'h0);
    tick();
    idle();
    #1 check_both("x9_after", 32'h22, 32'h22);
    tick();

    // test 5: reserve, hold, then release by write
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    rd(3, 0);
    tick();
    idle();
    tick();
    tick();
    check("x3_busy_a", 32'(busy_a[3]), 32'h1);
    check("x3_busy_b", 32'(busy_b[3]), 32'h1);
    check("x3_rd_busy_a", 32'(rd_busy_a), 32'h1);
    check("x3_rd_busy_b", 32'(rd_busy_b), 32'h1);
    drive_wr(0, 3, 32'hA5);
    #1 check("x3_byp_data_a", rd_data_a[31:0], 32'hA5);
    check("x3_byp_busy_a", 32'(rd_busy_a), 32'h0);
    check("x3_nobyp_busy_b", 32'(rd_busy_b), 32'h1);
    check("x3_nobyp_data_b", rd_data_b[31:0], 32'h0);
    tick();
    idle();
    rd(3, 3);
    #1 check_both("x3_after", 32'hA5, 32'hA5);
    check("x3_clr_a", 32'(busy_a[3]), 32'h0);
    check("x3_clr_b", 32'(busy_b[3]), 32'h0);
    tick();

    // test 6: reserve and write same register in one cycle
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    drive_wr(0, 4, 32'h77);
    rd(4, 4);
    #1 check("x4_byp_busy_a", 32'(rd_busy_a), 32'h0);
    tick();
    idle();
    #1 check_both("x4_after", 32'h77, 32'h77);
    check("x4_busy_a", 32'(busy_a[4]), 32'h1);
    check("x4_busy_b", 32'(busy_b[4]), 32'h1);
    check("x4_rd_busy_b", 32'(rd_busy_b), 32'h3);

    // re-reserve a busy register, an unrelated write, then release via port 1
    rsv_en   = 1'b1;
    rsv_addr = 5'd4;
    drive_wr(0, 8, 32'h88);
    tick();
    idle();
    #1 check("x4_rersv_busy", 32'(busy_a[4]), 32'h1);
    drive_wr(1, 4, 32'h99);
    tick();
    idle();
    #1 check_both("x4_port1_wr", 32'h99, 32'h99);
    check("x4_port1_clr", busy_b, 32'h0);
    rd(8, 7);
    #1 check("x8_data_b", rd_data_b[31:0], 32'h88);
    check("x7_kept_b", rd_data_b[63:32], 32'h12345678);
    tick();
    tick();

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
